// File: rtl/scan_sel_ctrl_pkg.sv
// Shared constants and FSM state encoding for the scan channel selector.
package scan_sel_ctrl_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/scan_sel_ctrl_if.sv
// Control/status bundle between a scan requester and scan_sel_ctrl.
interface scan_sel_ctrl_if #(parameter int DWELL_W = 8);
  import scan_sel_ctrl_pkg::*;

  logic               start;
  logic               stop;
  logic               cont;
  logic [DWELL_W-1:0] dwell;
  logic [NUM_CH-1:0]  mask;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, cont, dwell, mask,
    input  sel, sel_valid, busy, done
  );

  modport slave (
    input  start, stop, cont, dwell, mask,
    output sel, sel_valid, busy, done
  );

endinterface

// File: rtl/scan_sel_ctrl_next_sel.sv
// Finds the next enabled channel above cur, and the lowest enabled channel.
module scan_next_sel
  import scan_sel_ctrl_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next,
  output logic              wrap,
  output logic [SEL_W-1:0]  first
);

  always_comb begin
    first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) first = SEL_W'(i);
    end
  end

  // Walk downward so the lowest qualifying channel is the last one assigned.
  always_comb begin
    next = first;
    wrap = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        next = SEL_W'(i);
        wrap = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_sel_ctrl.sv
// Round-robin scan selector: steps sel through enabled channels, holding each
// for an effective dwell of max(dwell,1) cycles, one-shot or continuous.
//   state   | meaning
//   IDLE    | waiting for an accepted start, all outputs low
//   SCAN    | sel holds an enabled channel, dwell counter running
//   DONE    | one-shot pass finished, done high for one cycle
module scan_sel_ctrl
  import scan_sel_ctrl_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input logic            clk,
  input logic            rst,
  scan_sel_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic               cont_q, cont_d;

  logic [NUM_CH-1:0]  scan_mask;
  logic [SEL_W-1:0]   next_sel;
  logic [SEL_W-1:0]   first_sel;
  logic               wrap;
  logic [DWELL_W-1:0] eff_dwell;
  logic               start_ok;

  // In IDLE the finder looks at the live mask so the first channel is ready
  // on the accepting edge; afterwards only the latched mask matters.
  assign scan_mask = (state_q == ST_IDLE) ? bus.mask : mask_q;
  assign eff_dwell = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  assign start_ok  = bus.start && !bus.stop && (bus.mask != '0);

  scan_next_sel u_next_sel (
    .mask  (scan_mask),
    .cur   (sel_q),
    .next  (next_sel),
    .wrap  (wrap),
    .first (first_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      dwell_q     <= '0;
      mask_q      <= '0;
      cont_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      dwell_q     <= dwell_d;
      mask_q      <= mask_d;
      cont_q      <= cont_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    dwell_d     = dwell_q;
    mask_d      = mask_q;
    cont_d      = cont_q;

    case (state_q)
      ST_IDLE: begin
        sel_d       = '0;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (start_ok) begin
          state_d     = ST_SCAN;
          mask_d      = bus.mask;
          dwell_d     = eff_dwell;
          cont_d      = bus.cont;
          cnt_d       = eff_dwell;
          sel_d       = first_sel;
          sel_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      ST_SCAN: begin
        if (bus.stop) begin
          state_d     = ST_IDLE;
          sel_d       = '0;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
          cnt_d       = '0;
        end else if (cnt_q == DWELL_W'(1)) begin
          if (wrap && !cont_q) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            sel_d       = '0;
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
            cnt_d       = '0;
          end else begin
            sel_d = next_sel;
            cnt_d = dwell_q;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        sel_d       = '0;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
      end

      default: begin
        state_d     = ST_IDLE;
        sel_d       = '0;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_scan_sel_ctrl.sv
// Scoreboard bench for scan_sel_ctrl: a channel-list reference model predicts
// every cycle's outputs; a monitor pops and compares them after each edge.
module tb_scan_sel_ctrl;
  import scan_sel_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_sel_ctrl_if #(.DWELL_W(8)) bus ();

  scan_sel_ctrl #(.DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int sel;
    bit valid;
    bit busy;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  // Reference model: 0 idle, 1 scanning, 2 done pulse.
  int   m_mode = 0;
  int   m_chans[$];
  int   m_idx  = 0;
  int   m_rem  = 0;
  int   m_d    = 1;
  bit   m_cont = 1'b0;

  task automatic cycle(input bit r, input bit s, input bit p, input bit c,
                       input int dw, input int mk);
    exp_t e;
    @(negedge clk);
    rst       = r;
    bus.start = s;
    bus.stop  = p;
    bus.cont  = c;
    bus.dwell = 8'(dw);
    bus.mask  = 8'(mk);

    if (r) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: begin
          if (s && !p && (mk != 0)) begin
            m_chans.delete();
            for (int i = 0; i < 8; i++) if (mk[i]) m_chans.push_back(i);
            m_d    = (dw == 0) ? 1 : dw;
            m_cont = c;
            m_idx  = 0;
            m_rem  = m_d;
            m_mode = 1;
          end
        end
        1: begin
          if (p) begin
            m_mode = 0;
          end else begin
            m_rem--;
            if (m_rem == 0) begin
              m_rem = m_d;
              m_idx++;
              if (m_idx == m_chans.size()) begin
                if (m_cont) m_idx = 0;
                else        m_mode = 2;
              end
            end
          end
        end
        default: m_mode = 0;
      endcase
    end

    e.sel   = (m_mode == 1) ? m_chans[m_idx] : 0;
    e.valid = (m_mode == 1);
    e.busy  = (m_mode == 1);
    e.done  = (m_mode == 2);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.sel !== 3'(e.sel) || bus.sel_valid !== e.valid ||
            bus.busy !== e.busy || bus.done !== e.done) begin
          errors++;
          $display("FAIL outputs cycle %0d: got sel=%0d sel_valid=%b busy=%b done=%b, expected sel=%0d sel_valid=%b busy=%b done=%b",
                   cyc, bus.sel, bus.sel_valid, bus.busy, bus.done,
                   e.sel, e.valid, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    int mk;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.cont  = 1'b0;
    bus.dwell = '0;
    bus.mask  = '0;

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 2, 'hFF);

    // full one-shot pass, start right after reset release
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2, 'hFF);
    idle(20);
    // sparse mask, continuous, then stop
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1, 'hA5);
    idle(12);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(2);
    // zero dwell, single channel one-shot
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 'h10);
    idle(4);
    // single channel continuous
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3, 'h40);
    idle(8);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    // empty mask ignored
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2, 'h00);
    idle(3);
    // stop mid-scan at sel=3
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 3, 'hFF);
    idle(9);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(2);
    // reset mid-scan
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 2, 'hFF);
    idle(5);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(2);
    // start+stop together in idle, then start during scan with another mask
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1, 'hFF);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1, 'hFF);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4, 'h01);
    idle(10);

    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(7))
        0:       mk = 0;
        1:       mk = 1 << $urandom_range(7);
        default: mk = int'($urandom_range(255));
      endcase
      cycle(($urandom_range(199) == 0), ($urandom_range(7) == 0),
            ($urandom_range(39) == 0), 1'($urandom_range(1)),
            int'($urandom_range(4)), mk);
    end

    idle(3);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
